// File: rtl/sram_pkg.sv
// Shared constants for the external SRAM responder: state encoding, control-bit
// positions and bus widths, plus the per-state control word decode.
package sram_pkg;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    localparam int CE_N = 4;
    localparam int OE_N = 3;
    localparam int WE_N = 2;
    localparam int UB_N = 1;
    localparam int LB_N = 0;

    localparam logic [4:0] SRAM_IDLE = 5'b11111;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_SETUP  = 3'd1;
    localparam logic [2:0] ST_RD_STROBE = 3'd2;
    localparam logic [2:0] ST_RD_DONE   = 3'd3;
    localparam logic [2:0] ST_WR_SETUP  = 3'd4;
    localparam logic [2:0] ST_WR_STROBE = 3'd5;
    localparam logic [2:0] ST_WR_HOLD   = 3'd6;
    localparam logic [2:0] ST_WR_DONE   = 3'd7;

    // {CE_N, OE_N, WE_N, UB_N, LB_N} for the state the FSM is entering.
    function automatic logic [4:0] ctrl_word(input logic [2:0] st, input logic [1:0] be_mask);
        logic [4:0] w;
        w = SRAM_IDLE;
        case (st)
            ST_RD_SETUP, ST_WR_SETUP, ST_WR_HOLD: w = {1'b0, 1'b1, 1'b1, ~be_mask};
            ST_RD_STROBE:                         w = {1'b0, 1'b0, 1'b1, ~be_mask};
            ST_WR_STROBE:                         w = {1'b0, 1'b1, 1'b0, ~be_mask};
            default:                              w = SRAM_IDLE;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-word req/done responder driving a 256Kx16 asynchronous SRAM.
// Every pin is a flop loaded from the next-state decode, so strobes never glitch.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] Direcciones,
    inout  wire  [DATA_W-1:0] Datos,
    output logic [4:0]        sram_control
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [3:0]        r_cnt;
    logic [1:0]        r_be;
    logic [1:0]        w_be_next;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [4:0]        r_ctrl;
    logic              r_doe;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              w_last_strobe;
    logic [DATA_W-1:0] w_rd_masked;

    assign w_last_strobe = (r_cnt == 4'd0);
    assign w_be_next     = (r_state == ST_IDLE) ? be : r_be;
    assign w_rd_masked   = {r_be[1] ? Datos[15:8] : 8'h00, r_be[0] ? Datos[7:0] : 8'h00};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (req) w_next = we ? ST_WR_SETUP : ST_RD_SETUP;
            ST_RD_SETUP:  w_next = ST_RD_STROBE;
            ST_RD_STROBE: if (w_last_strobe) w_next = ST_RD_DONE;
            ST_RD_DONE:   w_next = ST_IDLE;
            ST_WR_SETUP:  w_next = ST_WR_STROBE;
            ST_WR_STROBE: if (w_last_strobe) w_next = ST_WR_HOLD;
            ST_WR_HOLD:   w_next = ST_WR_DONE;
            ST_WR_DONE:   w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_be    <= 2'b00;
            r_wdata <= '0;
            r_addr  <= '0;
            r_ctrl  <= SRAM_IDLE;
            r_doe   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_word(w_next, w_be_next);
            // Data bus is driven only while OE_N is guaranteed high.
            r_doe   <= (w_next == ST_WR_SETUP) || (w_next == ST_WR_STROBE) || (w_next == ST_WR_HOLD);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_RD_DONE) || (w_next == ST_WR_DONE);
            if (r_state == ST_IDLE && req) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_be    <= be;
            end
            if (r_state == ST_RD_SETUP || r_state == ST_WR_SETUP) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == ST_RD_STROBE || r_state == ST_WR_STROBE) && !w_last_strobe) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == ST_RD_STROBE && w_last_strobe) begin
                r_rdata <= w_rd_masked;
            end
        end
    end

    assign Datos        = r_doe ? r_wdata : 16'hzzzz;
    assign Direcciones  = r_addr;
    assign sram_control = r_ctrl;
    assign busy         = r_busy;
    assign done         = r_done;
    assign rdata        = r_rdata;

endmodule
